// File: rtl/reg_bank_write_arbiter.sv
// Round-robin write-port arbiter for a register bank with per-register write enables,
// plus a sequenced CLEAR that zeroes every register, one per cycle.
module reg_bank_write_arbiter #(
  parameter int WIDTH    = 16,
  parameter int NUM_REQ  = 4,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]  req_data,
  input  logic                      clear_req,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REGS-1:0]       reg_we,
  output logic [WIDTH-1:0]          wr_data,
  output logic                      busy,
  output logic                      addr_err
);

  localparam int PTR_W = (NUM_REQ  > 1) ? $clog2(NUM_REQ)  : 1;
  localparam int CLR_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic {ARB, CLEAR} state_t;

  state_t             state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [CLR_W-1:0]   clr_idx;

  logic [NUM_REQ-1:0] eligible;
  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic [ADDR_W-1:0]  win_addr;
  logic [WIDTH-1:0]   win_data;
  int                 scan;

  function automatic logic [NUM_REGS-1:0] onehot(input int idx);
    logic [NUM_REGS-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (i == idx) v[i] = 1'b1;
    return v;
  endfunction

  // The requester currently shown gnt is still holding req; mask it out.
  assign eligible = req & ~gnt;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = (int'(rr_ptr) + k) % NUM_REQ;
      if (!win_found && eligible[scan]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(scan);
      end
    end
  end

  assign win_addr = req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
  assign win_data = req_data[int'(win_idx)*WIDTH +: WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB;
      rr_ptr   <= '0;
      clr_idx  <= '0;
      gnt      <= '0;
      reg_we   <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      gnt      <= '0;
      reg_we   <= '0;
      addr_err <= 1'b0;
      case (state)
        ARB: begin
          busy <= 1'b0;
          if (clear_req) begin
            // Step 0 of the clear is issued right away so busy rises with reg_we[0].
            state   <= CLEAR;
            reg_we  <= onehot(0);
            wr_data <= '0;
            busy    <= 1'b1;
            clr_idx <= CLR_W'(1);
          end else if (win_found) begin
            gnt[win_idx] <= 1'b1;
            wr_data      <= win_data;
            rr_ptr       <= PTR_W'((int'(win_idx) + 1) % NUM_REQ);
            if (int'(win_addr) < NUM_REGS)
              reg_we <= onehot(int'(win_addr));
            else
              addr_err <= 1'b1;
          end
        end
        CLEAR: begin
          reg_we  <= onehot(int'(clr_idx));
          wr_data <= '0;
          busy    <= 1'b1;
          if (int'(clr_idx) == NUM_REGS - 1) begin
            state   <= ARB;
            clr_idx <= '0;
          end else begin
            clr_idx <= clr_idx + CLR_W'(1);
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule
